// File: rtl/trash_sequencer.sv
// Multi-cycle sequencer for the trash CPU: program store, PC, r0..r3, data memory,
// and a req/ack port to a shared external ALU.
module trash_sequencer #(
   parameter int unsigned PROG_BYTES = 16,
   parameter int unsigned MEM_BYTES  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       prog_en,
   input  logic [7:0] prog_byte,
   input  logic       run,
   output logic       alu_req,
   output logic [3:0] alu_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic       alu_ack,
   input  logic [7:0] alu_res,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       halted,
   output logic       busy,
   output logic [2:0] pc_dbg
);

   localparam logic [3:0] OpNop      = 4'h0;
   localparam logic [3:0] OpStore    = 4'h1;
   localparam logic [3:0] OpCalc     = 4'h2;
   localparam logic [3:0] OpMemStore = 4'h3;
   localparam logic [3:0] OpMemLoad  = 4'h4;
   localparam logic [3:0] OpJump     = 4'h5;
   localparam logic [3:0] OpJumpIf   = 4'h6;
   localparam logic [3:0] OpOut      = 4'h7;
   localparam logic [3:0] OpHalt     = 4'hF;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StFetch,
      StExec,
      StAluWait,
      StHalt
   } state_t;

   state_t      state_q;
   logic [2:0]  pc_q;
   logic [3:0]  load_ptr_q;
   logic [15:0] ir_q;
   logic [7:0]  regs_q [4];
   logic [7:0]  mem_q [MEM_BYTES];
   logic [7:0]  prog_mem [PROG_BYTES];
   logic [3:0]  alu_op_q;
   logic [3:0]  alu_a_q;
   logic [3:0]  alu_b_q;
   logic [1:0]  alu_dst_q;
   logic [7:0]  out_data_q;
   logic        out_valid_q;

   logic [15:0] fetch_word;
   logic [3:0]  ir_op;
   logic [7:0]  src_val;
   logic [7:0]  cmp_val;
   logic [2:0]  pc_inc;

   always_comb begin
      fetch_word = {prog_mem[{pc_q, 1'b0}], prog_mem[{pc_q, 1'b1}]};
      ir_op      = ir_q[15:12];
      src_val    = regs_q[ir_q[7:6]];
      cmp_val    = regs_q[ir_q[5:4]];
      pc_inc     = pc_q + 3'd1;
   end

   // The program store survives reset so a program can be rerun after an abort.
   always_ff @(posedge clk) begin
      if (!reset && prog_en) begin
         prog_mem[load_ptr_q] <= prog_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         pc_q        <= 3'd0;
         load_ptr_q  <= 4'd0;
         ir_q        <= 16'd0;
         alu_op_q    <= 4'd0;
         alu_a_q     <= 4'd0;
         alu_b_q     <= 4'd0;
         alu_dst_q   <= 2'd0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= 8'd0;
         end
         for (int i = 0; i < int'(MEM_BYTES); i++) begin
            mem_q[i] <= 8'd0;
         end
      end else begin
         out_valid_q <= 1'b0;
         if (prog_en) begin
            // Entering load from any state also abandons a pending ALU request.
            state_q    <= StLoad;
            load_ptr_q <= load_ptr_q + 4'd1;
         end else begin
            load_ptr_q <= 4'd0;
            unique case (state_q)
               StIdle: begin
                  if (run) begin
                     pc_q    <= 3'd0;
                     state_q <= StFetch;
                  end
               end
               StLoad: begin
                  state_q <= StIdle;
               end
               StFetch: begin
                  ir_q    <= fetch_word;
                  state_q <= StExec;
               end
               StExec: begin
                  state_q <= StFetch;
                  pc_q    <= pc_inc;
                  case (ir_op)
                     OpNop: ;
                     OpStore: regs_q[ir_q[9:8]] <= ir_q[7:0];
                     OpCalc: begin
                        alu_op_q  <= ir_q[11:8];
                        alu_a_q   <= src_val[7:4];
                        alu_b_q   <= src_val[3:0];
                        alu_dst_q <= ir_q[5:4];
                        pc_q      <= pc_q;
                        state_q   <= StAluWait;
                     end
                     OpMemStore: mem_q[ir_q[11:8]] <= ir_q[7:0];
                     OpMemLoad: regs_q[ir_q[7:6]] <= mem_q[ir_q[11:8]];
                     OpJump: pc_q <= ir_q[10:8];
                     OpJumpIf: begin
                        if (src_val == cmp_val) begin
                           pc_q <= ir_q[10:8];
                        end
                     end
                     OpOut: begin
                        out_data_q  <= regs_q[ir_q[9:8]];
                        out_valid_q <= 1'b1;
                     end
                     OpHalt: begin
                        pc_q    <= pc_q;
                        state_q <= StHalt;
                     end
                     default: ;
                  endcase
               end
               StAluWait: begin
                  if (alu_ack) begin
                     regs_q[alu_dst_q] <= alu_res;
                     pc_q              <= pc_inc;
                     state_q           <= StFetch;
                  end
               end
               StHalt: begin
                  if (!run) begin
                     state_q <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign alu_req   = (state_q == StAluWait);
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = (state_q == StHalt);
   assign busy      = (state_q == StFetch) || (state_q == StExec) || (state_q == StAluWait);
   assign pc_dbg    = pc_q;

endmodule

// File: doc/trash_sequencer.md
Name: trash_sequencer

Overview:
- Multi-cycle instruction sequencer for the trash CPU.
- Owns the program byte store, PC, register file r0..r3 and 16-byte data memory.
- Fetches 16-bit instructions and executes them under a state machine.
- Shares an external ALU through a req/ack handshake, so the ALU may take any number of cycles.

Parameters:
- PROG_BYTES, 16, program store depth in bytes (8 instructions, 2 bytes each); fixed, PC is 3 bits.
- MEM_BYTES, 16, data memory depth; addressed by 4 bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- prog_en  input  1  load mode; high = write prog_byte into program store each cycle
- prog_byte  input  8  byte to load
- run  input  1  level; starts execution from IDLE
- alu_req  output  1  ALU request, held until accepted
- alu_op  output  4  ALU opcode
- alu_a  output  4  operand A
- alu_b  output  4  operand B
- alu_ack  input  1  ALU result valid; transfer when alu_req && alu_ack
- alu_res  input  8  ALU result
- out_data  output  8  last OUT value
- out_valid  output  1  one-cycle pulse per OUT
- halted  output  1  high in HALT state
- busy  output  1  high in FETCH, EXEC or ALU_WAIT
- pc_dbg  output  3  current PC

Behaviour:
- Reset, synchronous:
  - state=IDLE, pc=0, load_ptr=0.
  - r0..r3=0, data memory=0.
  - All outputs 0.
  - Program store is not cleared.
- Load mode:
  - prog_en overrides everything. From any state, the next state is LOAD; alu_req drops next cycle.
  - In LOAD, each cycle writes prog[load_ptr] <= prog_byte; load_ptr increments, wrapping 15->0.
  - prog_en low: load_ptr clears to 0 and state goes to IDLE.
- Instruction format:
  - Instruction k = {prog[2k], prog[2k+1]}, high byte first.
  - Fields: op=[15:12], A=[11:8], B=[7:0].
- States:
  - IDLE: pc held. run=1 -> pc<=0, FETCH.
  - FETCH: ir <= instruction[pc] -> EXEC. One cycle.
  - EXEC: executes ir, then normally pc<=pc+1 (wraps 7->0) and goes to FETCH. Every non-ALU instruction takes exactly 2 cycles.
  - ALU_WAIT: alu_req=1; alu_op/alu_a/alu_b stay stable until the ack cycle.
    - On the ack cycle: dst <= alu_res, pc+1, FETCH.
    - alu_req is 0 the cycle after ack.
    - ack while req is low is ignored. No timeout.
  - HALT: halted=1. Leaves to IDLE only when run=0. run is otherwise ignored outside IDLE.
- Opcodes:
  - 0x0 NOP.
  - 0x1 STORE: reg[ir[9:8]] <= ir[7:0].
  - 0x2 CALC: alu_op=ir[11:8]; src=reg[ir[7:6]]; alu_a=src[7:4], alu_b=src[3:0]; dst=ir[5:4]. EXEC -> ALU_WAIT; pc unchanged until ack. Operands are latched at EXEC; a dst==src write does not disturb the request.
  - 0x3 MEMSTORE: mem[ir[11:8]] <= ir[7:0].
  - 0x4 MEMLOAD: reg[ir[7:6]] <= mem[ir[11:8]].
  - 0x5 JUMP: pc <= ir[10:8]; ir[11] ignored.
  - 0x6 JUMPIF: pc <= ir[10:8] if reg[ir[7:6]] == reg[ir[5:4]], else pc+1.
  - 0x7 OUT: out_data <= reg[ir[9:8]]. out_valid=1 for exactly the following cycle. out_data holds until the next OUT or reset.
  - 0xF HALT: pc unchanged -> HALT.
  - 0x8-0xE: treated as NOP.
- Simultaneous events and aborts:
  - reset beats prog_en, which beats all other inputs.
  - reset or prog_en in ALU_WAIT aborts the instruction; dst is unwritten.
- busy is 1 exactly in FETCH, EXEC and ALU_WAIT.
- pc_dbg = pc at all times.

Test Plan:
- Load, store, output:
  - Load bytes 10 A5 70 00 F0 00, pulse run.
  - Required: out_valid pulses once with out_data=0xA5; halted=1, pc_dbg=2.
  - Total cycles from run to HALT: 6.
- CALC with delayed ack:
  - STORE r0=0x34, then CALC op=0 src=r0 dst=r1, then OUT r1.
  - Hold alu_ack low 3 cycles.
  - Required: alu_req high 4 cycles with alu_a=3, alu_b=4, alu_op=0; alu_res=0x07 on the ack cycle.
  - Result: out_data=0x07, no extra req cycle.
- JUMPIF taken and not taken:
  - r2=r3=0x55, JUMPIF ->5: pc_dbg reaches 5.
  - With r3=0x56: pc advances by 1.
- MEMSTORE/MEMLOAD:
  - MEMSTORE mem[0xF]=0x9C, MEMLOAD r3<=mem[0xF], OUT r3.
  - Required: out_data=0x9C.
- Wrap and aborts:
  - Program with no HALT: pc wraps 7->0 and execution continues.
  - prog_en asserted during ALU_WAIT: alu_req=0 next cycle, dst unchanged, state LOAD.
  - Load 17 bytes: the 17th byte overwrites prog[0].
- Reset mid-run:
  - reset asserted in EXEC: next cycle all outputs 0 and state IDLE; program store is retained.
  - Rerun gives the identical out_data sequence.
